// File: rtl/muldiv_special_pkg.sv
// muldiv_special_pkg
//   Shared definitions for the iterative multiply/divide unit: operation
//   encodings, FSM state encoding, the divide-by-zero quotient constant and
//   small op-decode helpers.
package muldiv_special_pkg;

  localparam int DATA_WIDTH = 32;

  // Operation encodings, sampled together with start.
  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Quotient returned when the divisor is zero.
  localparam logic [DATA_WIDTH-1:0] DIV0_QUOT = {DATA_WIDTH{1'b1}};

  function automatic logic op_is_div(input logic [1:0] op);
    return !((op == OP_MULU) || (op == OP_MUL));
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath
//   Purely combinational datapath for muldiv_special.
//   Ports:
//     is_div_i           : 1 = divide iteration, 0 = multiply iteration
//     hi_i / lo_i        : working accumulator (MUL: partial product / multiplier,
//                          DIV: partial remainder / dividend-quotient)
//     m_i                : multiplicand magnitude (MUL) or divisor magnitude (DIV)
//     step_hi_o/_lo_o    : accumulator after one radix-2 iteration
//     sa_i / sb_i        : operand sign flags (always 0 for unsigned ops)
//     b_zero_i           : divisor was zero
//     a_orig_i           : dividend as originally presented
//     res_lo_o/res_hi_o  : final sign-corrected result words
module muldiv_datapath
  import muldiv_special_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic             sa_i,
  input  logic             sb_i,
  input  logic             b_zero_i,
  input  logic [WIDTH-1:0] a_orig_i,
  output logic [WIDTH-1:0] step_hi_o,
  output logic [WIDTH-1:0] step_lo_o,
  output logic [WIDTH-1:0] res_lo_o,
  output logic [WIDTH-1:0] res_hi_o
);

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] prod_s;

  // Single iteration: shift-add for MUL, restoring trial subtract for DIV.
  always_comb begin
    mul_sum_s   = {1'b0, hi_i};
    div_shift_s = {hi_i, lo_i[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, m_i};
    step_hi_o   = hi_i;
    step_lo_o   = lo_i;
    if (is_div_i) begin
      // Negative trial difference (MSB set) means restore and shift in a 0.
      if (!div_diff_s[WIDTH]) begin
        step_hi_o = div_diff_s[WIDTH-1:0];
        step_lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_o = div_shift_s[WIDTH-1:0];
        step_lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo_i[0]) begin
        mul_sum_s = {1'b0, hi_i} + {1'b0, m_i};
      end else begin
        mul_sum_s = {1'b0, hi_i};
      end
      // The carry out of the add becomes the new top bit after the shift.
      step_hi_o = mul_sum_s[WIDTH:1];
      step_lo_o = {mul_sum_s[0], lo_i[WIDTH-1:1]};
    end
  end

  // Sign correction and divide special cases. The signed overflow case
  // (most negative / -1) falls out naturally: |a| / 1 = 0x80..0, whose
  // negation is itself, with a zero remainder.
  always_comb begin
    prod_s   = {hi_i, lo_i};
    res_lo_o = lo_i;
    res_hi_o = hi_i;
    if (is_div_i) begin
      if (b_zero_i) begin
        res_lo_o = DIV0_QUOT[WIDTH-1:0];
        res_hi_o = a_orig_i;
      end else begin
        res_lo_o = (sa_i ^ sb_i) ? (~lo_i + ONE_W) : lo_i;
        res_hi_o = sa_i ? (~hi_i + ONE_W) : hi_i;
      end
    end else begin
      if (sa_i ^ sb_i) begin
        prod_s = ~{hi_i, lo_i} + ONE_2W;
      end else begin
        prod_s = {hi_i, lo_i};
      end
      res_lo_o = prod_s[WIDTH-1:0];
      res_hi_o = prod_s[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/muldiv_special.sv
// muldiv_special
//   Iterative multiply/divide unit, one radix-2 iteration per clock.
//   result_lo feeds the register-file special write path, special_en is its
//   write enable (identical to done).
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     start, op         : request and operation (MULU/MUL/DIVU/DIV)
//     flush             : abort the in-flight operation
//     opa, opb          : multiplicand/dividend, multiplier/divisor
//     busy              : operation in progress
//     done, special_en  : one-cycle result-valid pulse
//     result_lo/_hi     : product low/high or quotient/remainder
module muldiv_special
  import muldiv_special_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             special_en,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, a_orig_q, a_orig_d;
  logic             is_div_q, is_div_d, sa_q, sa_d, sb_q, sb_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic             done_q, done_d, busy_q, busy_d;

  logic             sgn_s, sa_s, sb_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH-1:0] step_hi_s, step_lo_s, fix_lo_s, fix_hi_s;

  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .is_div_i  (is_div_q),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .m_i       (m_q),
    .sa_i      (sa_q),
    .sb_i      (sb_q),
    .b_zero_i  (b_zero_q),
    .a_orig_i  (a_orig_q),
    .step_hi_o (step_hi_s),
    .step_lo_o (step_lo_s),
    .res_lo_o  (fix_lo_s),
    .res_hi_o  (fix_hi_s)
  );

  // Operand magnitudes and sign flags for the request on the inputs.
  always_comb begin
    sgn_s   = op_is_signed(op);
    sa_s    = sgn_s & opa[WIDTH-1];
    sb_s    = sgn_s & opb[WIDTH-1];
    a_mag_s = sa_s ? (~opa + ONE_W) : opa;
    b_mag_s = sb_s ? (~opb + ONE_W) : opb;
  end

  // Next-state and datapath register control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    a_orig_d = a_orig_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    b_zero_d = b_zero_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          is_div_d = op_is_div(op);
          sa_d     = sa_s;
          sb_d     = sb_s;
          a_orig_d = opa;
          b_zero_d = (opb == {WIDTH{1'b0}});
          hi_d     = {WIDTH{1'b0}};
          // MUL: lo holds the multiplier, m the multiplicand.
          // DIV: lo holds the dividend, m the divisor.
          lo_d     = op_is_div(op) ? a_mag_s : b_mag_s;
          m_d      = op_is_div(op) ? b_mag_s : a_mag_s;
          cnt_d    = CNT_INI;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          hi_d  = step_hi_s;
          lo_d  = step_lo_s;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          res_lo_d = fix_lo_s;
          res_hi_d = fix_hi_s;
          done_d   = 1'b1;
        end else begin
          done_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      m_q      <= {WIDTH{1'b0}};
      a_orig_q <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      b_zero_q <= 1'b0;
      res_lo_q <= {WIDTH{1'b0}};
      res_hi_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      a_orig_q <= a_orig_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      b_zero_q <= b_zero_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign special_en = done_q;
  assign result_lo  = res_lo_q;
  assign result_hi  = res_hi_q;

endmodule

// File: tb/tb_muldiv_special.sv
module tb_muldiv_special;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [1:0]   op;
  logic [W-1:0] opa, opb;
  logic         busy, done, special_en;
  logic [W-1:0] result_lo, result_hi;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done;

  muldiv_special dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .flush      (flush),
    .opa        (opa),
    .opb        (opb),
    .busy       (busy),
    .done       (done),
    .special_en (special_en),
    .result_lo  (result_lo),
    .result_hi  (result_hi)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble operands after acceptance, and wait for
  // done. Returns in the done cycle.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_lo,
                       input logic [W-1:0] exp_hi);
    int cyc;
    start = 1'b1; op = o; opa = a; opb = b;
    step();
    check({tag, " busy after accept"}, 64'(busy), 64'd1);
    start = 1'b0;
    opa = $urandom; opb = $urandom; op = 2'($urandom_range(0, 3));
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " special_en"}, 64'(special_en), 64'd1);
    check({tag, " busy in done"}, 64'(busy), 64'd0);
    check({tag, " lo"}, 64'(result_lo), 64'(exp_lo));
    check({tag, " hi"}, 64'(result_hi), 64'(exp_hi));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
    opa = 32'h0; opb = 32'h0;
    step(); step();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sen", 64'(special_en), 64'd0);
    check("reset lo", 64'(result_lo), 64'd0);
    check("reset hi", 64'(result_hi), 64'd0);
    reset = 1'b0;
    step();

    do_op("mulu", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0001);
    step();
    check("mulu done pulse", 64'(done), 64'd0);
    check("mulu sen pulse", 64'(special_en), 64'd0);
    check("mulu lo stable", 64'(result_lo), 64'hFFFF_FFFE);

    do_op("mul", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    do_op("mul negneg", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    do_op("div", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_op("div posneg", 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    do_op("divu", 2'b10, 32'd100, 32'd7, 32'd14, 32'd2);
    do_op("divu0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    do_op("div0 signed", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    do_op("div ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    // Back-to-back: start issued in the done cycle of the previous op.
    do_op("b2b", 2'b00, 32'd3, 32'd4, 32'd12, 32'd0);
    step();

    // Flush in IDLE blocks a simultaneous start.
    start = 1'b1; flush = 1'b1; op = 2'b01; opa = 32'd5; opb = 32'd5;
    step();
    check("idle flush blocks start", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;

    // Flush mid-operation.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    n_done = 0;
    repeat (40) begin
      if (done) n_done++;
      step();
    end
    check("flush no done", 64'(n_done), 64'd0);
    check("flush lo kept", 64'(result_lo), 64'd12);
    check("flush hi kept", 64'(result_hi), 64'd0);

    // Reset mid-operation.
    start = 1'b1; op = 2'b00; opa = 32'hFFFF_FFFF; opb = 32'h0000_0002;
    step();
    start = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset lo", 64'(result_lo), 64'd0);
    check("mid reset hi", 64'(result_hi), 64'd0);
    n_done = 0;
    repeat (40) begin
      if (done) n_done++;
      step();
    end
    check("mid reset no done", 64'(n_done), 64'd0);

    // Start held high while busy: only one operation completes.
    start = 1'b1; op = 2'b10; opa = 32'd100; opb = 32'd7;
    n_done = 0;
    repeat (20) begin
      if (done) n_done++;
      step();
    end
    start = 1'b0;
    repeat (40) begin
      if (done) n_done++;
      step();
    end
    check("held start one done", 64'(n_done), 64'd1);
    check("held start lo", 64'(result_lo), 64'd14);
    check("held start hi", 64'(result_hi), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_special.md
Name: muldiv_special

Overview:
- Iterative multiply/divide unit in the EX stage. Computes one 32-bit radix-2 iteration per clock.
- Its results go to the register file special-write path: result_lo drives Special_i and special_en drives Special_En, which writes register s8.
- Takes the multi-cycle MUL/DIV work out of the single-cycle ALU. The hazard logic stalls on busy.

Parameters:
- WIDTH, 32, operand and result width; equals `DataWidth. Iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- op  input  2  operation: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed); sampled with start.
- flush  input  1  abort the in-flight operation (pipeline squash).
- opa  input  WIDTH  multiplicand or dividend.
- opb  input  WIDTH  multiplier or divisor.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when results are valid.
- special_en  output  1  register file s8 write enable; equal to done.
- result_lo  output  WIDTH  product low word or quotient; drives Special_i.
- result_hi  output  WIDTH  product high word or remainder.

Behaviour:
- Reset (reset=1 at posedge) forces state IDLE, busy=0, done=0, special_en=0, result_lo=0, result_hi=0, counter=0. Reset overrides start and flush in the same cycle.
- States:
  - IDLE: start=1 and flush=0 → latch operands as magnitudes (signed ops take the absolute value; the result sign is recorded) → RUN, counter=WIDTH.
  - RUN: one iteration per cycle, counter decrements. Counter reaching 1 at the edge → FIX.
  - FIX: apply sign correction and special cases, load result_lo/result_hi, done=1 → IDLE next edge.
- Latency: start accepted at edge E0 → busy=1 after E0. done=special_en=1 for exactly the cycle after edge E0+WIDTH+1, with busy=0 in that same cycle. A new start is accepted in the done cycle.
- start while busy=1 is ignored; no queueing.
- flush=1 in RUN or FIX → IDLE at the next edge. No done; result_lo/result_hi keep their previous values. flush in IDLE also blocks a simultaneous start.
- Multiply: shift-add over the 2*WIDTH product. Signed result is the two's complement of the full 2*WIDTH product.
- Divide: restoring, one quotient bit per cycle.
  - Signed: quotient sign = sign(a) XOR sign(b); remainder takes the dividend's sign.
- Divide by zero: result_lo = all-ones, result_hi = opa (original), same latency, no exception.
- Signed overflow (0x80000000 / 0xFFFFFFFF): result_lo = 0x80000000, result_hi = 0.
- result_lo/result_hi are stable from the done cycle until the next completed operation.
- Operand inputs may change after acceptance; only the latched copies are used.

Decomposition:
- Shared header (alongside `DataWidth, `RESET_ON, `s8): op encodings OP_MULU/OP_MUL/OP_DIVU/OP_DIV, state encodings, DIV0_QUOT constant.
- One natural sub-module, muldiv_datapath: the combinational single-iteration step (add/shift for MUL, trial subtract for DIV) plus the sign-fix logic. The FSM and counter stay in muldiv_special.

Test Plan:
- MULU 0xFFFFFFFF x 0x00000002 → after WIDTH+1 cycles: done=special_en=1 for one cycle, result_hi=0x00000001, result_lo=0xFFFFFFFE, busy low in the done cycle.
- MUL -3 x 7 (0xFFFFFFFD, 0x00000007) → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB.
- DIV -7 / 2 → result_lo=0xFFFFFFFD (-3), result_hi=0xFFFFFFFF (-1). DIVU 100/7 → result_lo=14, result_hi=2.
- DIVU 5/0 → result_lo=0xFFFFFFFF, result_hi=5. DIV 0x80000000/0xFFFFFFFF → result_lo=0x80000000, result_hi=0.
- Mid-op events:
  - start MUL, flush at cycle 10 → busy=0 next cycle, no done, results unchanged.
  - Repeat with reset at cycle 10 instead → all outputs 0.
- Start held high during busy → exactly one done. Back-to-back start asserted in the done cycle → second done exactly WIDTH+1 cycles later.
